// File: rtl/bcd_converter_seq.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_converter_seq
//  Purpose  : Sequential binary-to-BCD converter (shift-and-add-3), one input
//             bit per clock, signed/unsigned per conversion, sign reported
//             separately, sticky overflow when DIGITS is too small.
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_converter_seq #(
   parameter int WIDTH  = 32,
   parameter int DIGITS = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [WIDTH-1:0]      binary,
   input  logic                  signed_en,
   output logic                  busy,
   output logic                  done,
   output logic                  neg,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  overflow
);

   localparam int              BCD_W    = 4 * DIGITS;
   localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [WIDTH-1:0] MAG_ONE  = WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            state;
   state_t            state_next;

   // Working registers for the conversion in flight
   logic [WIDTH-1:0]  mag_work;
   logic [BCD_W-1:0]  dig_work;
   logic              neg_work;
   logic              ovf_work;
   logic [CNT_W-1:0]  cnt;

   // Combinational helpers
   logic              accept;
   logic              shift_last;
   logic              neg_in;
   logic [WIDTH-1:0]  mag_in;
   logic [BCD_W-1:0]  dig_adj;
   logic [BCD_W-1:0]  dig_shifted;
   logic              top_out;

   // Sign/magnitude split of the incoming operand. The most negative value
   // negates to itself, which read as unsigned is exactly its magnitude.
   assign neg_in = signed_en & binary[WIDTH-1];
   assign mag_in = neg_in ? ((~binary) + MAG_ONE) : binary;

   // Add-3 correction: every digit of 5 or more is bumped before the shift so
   // that the doubling carries correctly into the next decade.
   generate
      for (genvar i = 0; i < DIGITS; i++) begin : g_adj
         assign dig_adj[4*i +: 4] = (dig_work[4*i +: 4] >= 4'd5)
                                  ? (dig_work[4*i +: 4] + 4'd3)
                                  : dig_work[4*i +: 4];
      end
   endgenerate

   // Digit chain shifted one place, fed by the magnitude MSB; the bit leaving
   // the top digit is a decade that does not fit and marks overflow.
   assign dig_shifted = {dig_adj[BCD_W-2:0], mag_work[WIDTH-1]};
   assign top_out     = dig_adj[BCD_W-1];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake decode
   always_comb begin
      state_next = state;
      busy       = (state != IDLE);
      done       = 1'b0;
      accept     = 1'b0;
      shift_last = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt == '0) begin
               shift_last = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Working datapath: load on acceptance, one double-dabble step per SHIFT cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mag_work <= '0;
         dig_work <= '0;
         neg_work <= 1'b0;
         ovf_work <= 1'b0;
         cnt      <= '0;
      end else if (accept) begin
         mag_work <= mag_in;
         dig_work <= '0;
         neg_work <= neg_in;
         ovf_work <= 1'b0;
         cnt      <= CNT_LAST;
      end else if (state == SHIFT) begin
         mag_work <= mag_work << 1;
         dig_work <= dig_shifted;
         if (top_out) begin
            ovf_work <= 1'b1;
         end
         if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
         end
      end
   end

   // Result registers: updated only on the edge entering DONE, held otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd      <= '0;
         neg      <= 1'b0;
         overflow <= 1'b0;
      end else if (shift_last) begin
         bcd      <= dig_shifted;
         neg      <= neg_work;
         overflow <= ovf_work | top_out;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bcd_converter_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_converter_seq
//  Purpose  : Scoreboard bench for bcd_converter_seq (32/10 and 8/2 builds)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_converter_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   // 32-bit / 10-digit instance
   logic        start_a, signed_a;
   logic [31:0] bin_a;
   logic        busy_a, done_a, neg_a, ovf_a;
   logic [39:0] bcd_a;

   // 8-bit / 2-digit instance
   logic        start_b, signed_b;
   logic [7:0]  bin_b;
   logic        busy_b, done_b, neg_b, ovf_b;
   logic [7:0]  bcd_b;

   bcd_converter_seq #(.WIDTH(32), .DIGITS(10)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .binary(bin_a),
      .signed_en(signed_a), .busy(busy_a), .done(done_a), .neg(neg_a),
      .bcd(bcd_a), .overflow(ovf_a)
   );

   bcd_converter_seq #(.WIDTH(8), .DIGITS(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .binary(bin_b),
      .signed_en(signed_b), .busy(busy_b), .done(done_b), .neg(neg_b),
      .bcd(bcd_b), .overflow(ovf_b)
   );

   typedef struct {
      logic [39:0] bcd;
      logic        neg;
      logic        ovf;
      longint      due;
   } exp_t;

   exp_t   q_a[$];
   exp_t   q_b[$];
   exp_t   held_a, held_b;
   int     n_vec = 0;
   int     n_bad = 0;
   longint cyc   = 0;
   int     blen_a = 0;
   int     blen_b = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: decimal digits of the magnitude by plain division
   function automatic exp_t model(input longint unsigned v, input int w,
                                  input bit s, input int nd);
      exp_t e;
      longint unsigned m;
      e.neg = s && (((v >> (w - 1)) & 64'd1) != 0);
      m     = e.neg ? ((64'd1 << w) - v) : v;
      e.bcd = '0;
      for (int i = 0; i < nd; i++) begin
         e.bcd[4*i +: 4] = 4'(m % 10);
         m = m / 10;
      end
      e.ovf = (m != 0);
      e.due = 0;
      return e;
   endfunction

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor A: pops on done, checks result, latency, busy length and hold
   always @(negedge clk) begin : mon_a
      exp_t e;
      if (!rst_n) begin
         blen_a     = 0;
         held_a.bcd = '0;
         held_a.neg = 1'b0;
         held_a.ovf = 1'b0;
      end else begin
         if (busy_a) blen_a++;
         else if (blen_a != 0) begin
            check("a_busy_len", 64'(blen_a), 64'd33);
            blen_a = 0;
         end
         if (done_a) begin
            if (q_a.size() == 0) check("a_unexpected_done", 64'd1, 64'd0);
            else begin
               e = q_a.pop_front();
               check("a_bcd", 64'(bcd_a), 64'(e.bcd));
               check("a_neg", 64'(neg_a), 64'(e.neg));
               check("a_ovf", 64'(ovf_a), 64'(e.ovf));
               check("a_latency", 64'(cyc), 64'(e.due));
               held_a = e;
            end
         end else begin
            check("a_hold", {23'd0, neg_a, ovf_a, bcd_a},
                  {23'd0, held_a.neg, held_a.ovf, held_a.bcd});
         end
      end
   end

   // Monitor B: same duties for the narrow instance
   always @(negedge clk) begin : mon_b
      exp_t e;
      if (!rst_n) begin
         blen_b     = 0;
         held_b.bcd = '0;
         held_b.neg = 1'b0;
         held_b.ovf = 1'b0;
      end else begin
         if (busy_b) blen_b++;
         else if (blen_b != 0) begin
            check("b_busy_len", 64'(blen_b), 64'd9);
            blen_b = 0;
         end
         if (done_b) begin
            if (q_b.size() == 0) check("b_unexpected_done", 64'd1, 64'd0);
            else begin
               e = q_b.pop_front();
               check("b_bcd", 64'(bcd_b), 64'(e.bcd));
               check("b_neg", 64'(neg_b), 64'(e.neg));
               check("b_ovf", 64'(ovf_b), 64'(e.ovf));
               check("b_latency", 64'(cyc), 64'(e.due));
               held_b = e;
            end
         end else begin
            check("b_hold", {54'd0, neg_b, ovf_b, bcd_b},
                  {54'd0, held_b.neg, held_b.ovf, held_b.bcd[7:0]});
         end
      end
   end

   // Issue one conversion on A; called and returns at a falling edge
   task automatic send_a(input logic [31:0] v, input bit s);
      exp_t e;
      int   t = 0;
      while (busy_a && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (busy_a) check("a_idle_timeout", 64'd1, 64'd0);
      e     = model(64'(v), 32, s, 10);
      e.due = cyc + 33;
      q_a.push_back(e);
      start_a  = 1'b1;
      bin_a    = v;
      signed_a = s;
      @(negedge clk);
      start_a  = 1'b0;
      bin_a    = $urandom;
      signed_a = 1'($urandom);
   endtask

   task automatic send_b(input logic [7:0] v, input bit s);
      exp_t e;
      int   t = 0;
      while (busy_b && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (busy_b) check("b_idle_timeout", 64'd1, 64'd0);
      e     = model(64'(v), 8, s, 2);
      e.due = cyc + 9;
      q_b.push_back(e);
      start_b  = 1'b1;
      bin_b    = v;
      signed_b = s;
      @(negedge clk);
      start_b  = 1'b0;
      bin_b    = 8'($urandom);
      signed_b = 1'($urandom);
   endtask

   // Stimulus
   initial begin
      int t;
      rst_n   = 1'b0;
      start_a = 1'b0; signed_a = 1'b0; bin_a = '0;
      start_b = 1'b0; signed_b = 1'b0; bin_b = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Directed corner values
      send_a(32'd1234567890, 1'b0);
      send_a(32'hFFFF_FFFF, 1'b1);
      send_a(32'hFFFF_FFFF, 1'b0);
      send_a(32'h8000_0000, 1'b1);
      send_a(32'd0, 1'b1);
      send_a(32'd0, 1'b0);
      send_a(32'h7FFF_FFFF, 1'b1);
      send_a(32'd9999999, 1'b1);

      // Request during SHIFT and during DONE must be dropped
      send_a(32'd1234, 1'b0);
      repeat (5) @(negedge clk);
      start_a = 1'b1; bin_a = 32'd42; signed_a = 1'b0;
      @(negedge clk);
      start_a = 1'b0;
      t = 0;
      while (!done_a && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!done_a) check("a_done_timeout", 64'd1, 64'd0);
      start_a = 1'b1; bin_a = 32'd42;
      @(negedge clk);
      start_a = 1'b0;

      // Random operands, mixed wide and small
      for (int i = 0; i < 20; i++) begin
         if (i % 3 == 0) send_a(32'($urandom_range(0, 999)), 1'($urandom));
         else            send_a($urandom, 1'($urandom));
      end

      // Narrow instance: overflow boundary and signed cases
      send_b(8'd255, 1'b0);
      send_b(8'd99, 1'b0);
      send_b(8'd100, 1'b0);
      send_b(8'h80, 1'b1);
      send_b(8'd0, 1'b1);
      send_b(8'hF7, 1'b1);
      for (int i = 0; i < 16; i++) send_b(8'($urandom), 1'($urandom));

      // Reset in the middle of a conversion
      t = 0;
      while ((busy_a || busy_b) && t < 100) begin
         @(negedge clk);
         t++;
      end
      send_a(32'd55555, 1'b0);
      repeat (9) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check("rst_async_outputs", {20'd0, busy_a, done_a, neg_a, ovf_a, bcd_a}, 64'd0);
      q_a.delete();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      send_a(32'd7, 1'b0);

      // Drain scoreboards, then watch for stray done pulses
      t = 0;
      while ((q_a.size() != 0 || q_b.size() != 0) && t < 500) begin
         @(negedge clk);
         t++;
      end
      check("drain_pending", 64'(q_a.size() + q_b.size()), 64'd0);
      repeat (50) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
